// File: rtl/dcache_maint_sequencer.sv
// Bulk DCache flush/invalidate sequencer: borrows the DCache ports, walks a line range,
// writes dirty lines back on the ring (8 WriteData slots + 1 Address slot) and updates status.
module dcache_maint_sequencer #(
  parameter logic [3:0] SLOT_ADDRESS   = 4'd2,
  parameter logic [3:0] SLOT_WRITEDATA = 4'd3,
  parameter int         LINE_WORDS     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  cmdLine,
  input  logic [6:0]  cmdCount,
  input  logic        cmdInvalidate,
  output logic        done,
  output logic        portReq,
  input  logic        portGrant,
  output logic [6:0]  lineAddr,
  input  logic [20:0] lineTag,
  input  logic [1:0]  lineStatus,
  output logic        statusWe,
  output logic [1:0]  statusD,
  output logic [9:0]  dataAddr,
  input  logic [31:0] dataIn,
  input  logic [3:0]  whichCore,
  output logic [31:0] ringOut,
  output logic [3:0]  slotTypeOut,
  output logic [3:0]  sourceOut,
  output logic        driveRing,
  output logic        wantsToken,
  input  logic        acquireToken
);

  localparam logic [1:0] ST_INVALID  = 2'd0;
  localparam logic [1:0] ST_SHARED   = 2'd1;
  localparam logic [1:0] ST_MODIFIED = 2'd3;
  localparam logic [2:0] LAST_WORD   = 3'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, LOOKUP, WAIT_TOKEN, SEND_DATA, SEND_WA, UPDATE, DONE
  } state_t;

  state_t      state, stateNext;
  logic [6:0]  cur, curNext;
  logic [6:0]  remaining, remainingNext;
  logic        op, opNext;
  logic [20:0] tagLatch, tagNext;
  logic [2:0]  wordIdx, wordNext;

  assign sourceOut = whichCore;

  // Only the state is reset; the command/line registers are always loaded before use.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
    cur       <= curNext;
    remaining <= remainingNext;
    op        <= opNext;
    tagLatch  <= tagNext;
    wordIdx   <= wordNext;
  end

  always_comb begin
    stateNext     = state;
    curNext       = cur;
    remainingNext = remaining;
    opNext        = op;
    tagNext       = tagLatch;
    wordNext      = wordIdx;
    done          = 1'b0;
    portReq       = 1'b0;
    lineAddr      = 7'd0;
    statusWe      = 1'b0;
    statusD       = ST_INVALID;
    dataAddr      = 10'd0;
    ringOut       = 32'd0;
    slotTypeOut   = 4'd0;
    driveRing     = 1'b0;
    wantsToken    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          curNext       = cmdLine;
          remainingNext = cmdCount;
          opNext        = cmdInvalidate;
          stateNext     = REQ;
        end
      end

      REQ: begin
        portReq = 1'b1;
        if (portGrant) stateNext = LOOKUP;
      end

      LOOKUP: begin
        portReq  = 1'b1;
        lineAddr = cur;
        if (!op && lineStatus == ST_MODIFIED) begin
          // Word 0 address goes out now so dataIn is ready on the first token cycle.
          tagNext   = lineTag;
          dataAddr  = {cur, 3'd0};
          wordNext  = 3'd0;
          stateNext = WAIT_TOKEN;
        end else begin
          if (op) begin
            statusWe = 1'b1;
            statusD  = ST_INVALID;
          end
          if (remaining == 7'd0) begin
            stateNext = DONE;
          end else begin
            curNext       = cur + 7'd1;
            remainingNext = remaining - 7'd1;
          end
        end
      end

      WAIT_TOKEN: begin
        portReq    = 1'b1;
        wantsToken = 1'b1;
        dataAddr   = {cur, 3'd0};
        if (acquireToken) begin
          driveRing   = 1'b1;
          slotTypeOut = SLOT_WRITEDATA;
          ringOut     = dataIn;
          dataAddr    = {cur, 3'd1};
          wordNext    = 3'd1;
          stateNext   = SEND_DATA;
        end
      end

      SEND_DATA: begin
        portReq     = 1'b1;
        driveRing   = 1'b1;
        slotTypeOut = SLOT_WRITEDATA;
        ringOut     = dataIn;
        dataAddr    = {cur, wordIdx + 3'd1};
        wordNext    = wordIdx + 3'd1;
        if (wordIdx == LAST_WORD) stateNext = SEND_WA;
      end

      SEND_WA: begin
        portReq     = 1'b1;
        driveRing   = 1'b1;
        slotTypeOut = SLOT_ADDRESS;
        ringOut     = {4'b0000, tagLatch, cur};
        stateNext   = UPDATE;
      end

      UPDATE: begin
        portReq  = 1'b1;
        lineAddr = cur;
        statusWe = 1'b1;
        statusD  = ST_SHARED;
        if (remaining == 7'd0) begin
          stateNext = DONE;
        end else begin
          curNext       = cur + 7'd1;
          remainingNext = remaining - 7'd1;
          stateNext     = LOOKUP;
        end
      end

      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule
